// File: rtl/detector_jogada_if.sv
// -----------------------------------------------------------------------------
// detector_jogada_if
// Groups the play-detector signals exchanged with the rest of the memory-game
// datapath.
//   master modport : drives habilita, zera_timeout, chaves; observes the rest
//   slave modport  : the detector itself
// Signals:
//   habilita            level, 1 = accept plays and count timeout
//   zera_timeout        synchronous clear of timeout counter and flag
//   chaves[3:0]         raw player keys
//   jogada[3:0]         last accepted play
//   jogada_feita        one-cycle pulse per accepted play
//   timeout             sticky timeout flag
//   db_estado[2:0]      FSM state encoding
//   db_contagem_timeout timeout counter value
//   db_chave_invalida   non-one-hot key pattern rejected
// -----------------------------------------------------------------------------
interface detector_jogada_if #(
    parameter int TIMEOUT_CYCLES = 3000
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic           habilita;
    logic           zera_timeout;
    logic [3:0]     chaves;
    logic [3:0]     jogada;
    logic           jogada_feita;
    logic           timeout;
    logic [2:0]     db_estado;
    logic [W-1:0]   db_contagem_timeout;
    logic           db_chave_invalida;

    modport master (
        output habilita, zera_timeout, chaves,
        input  jogada, jogada_feita, timeout,
        input  db_estado, db_contagem_timeout, db_chave_invalida
    );

    modport slave (
        input  habilita, zera_timeout, chaves,
        output jogada, jogada_feita, timeout,
        output db_estado, db_contagem_timeout, db_chave_invalida
    );
endinterface

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Input stage of the memory-game datapath: debounces the four player keys,
// registers the accepted play with a single-cycle jogada_feita pulse, and runs
// the per-play timeout counter with a sticky timeout flag.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    detector_jogada_if.slave (keys/enable in, play/timeout/debug out)
// Parameters:
//   DEBOUNCE_CYCLES  identical non-zero samples needed to accept a play (>= 2)
//   TIMEOUT_CYCLES   cycles allowed per play
// Build option:
//   MULTIKEY_REJECT_EN  when defined, non-one-hot key patterns are never
//                       accepted and db_chave_invalida flags them; otherwise
//                       any non-zero pattern is a valid play.
// -----------------------------------------------------------------------------
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES  = 3000
) (
    input  logic               clock,
    input  logic               reset,
    detector_jogada_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        SOLTA    = 3'd1,
        AGUARDA  = 3'd2,
        FILTRA   = 3'd3,
        EMITE    = 3'd4,
        ESGOTADO = 3'd5
    } estado_t;

    estado_t           estado_r;
    logic [3:0]        candidato_r;
    logic [3:0]        jogada_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              timeout_r;
    logic              jogada_feita_r;

    logic              chave_invalida_s;
    logic              conta_s;
    logic              deb_fim_s;
    logic              expira_s;

`ifdef MULTIKEY_REJECT_EN
    // True only for exactly one bit set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Multi-key patterns are not valid candidates in this build.
    assign chave_invalida_s = (bus.chaves != 4'd0) && !is_one_hot(bus.chaves);
`else
    // Every non-zero pattern is a valid candidate in this build.
    assign chave_invalida_s = 1'b0;
`endif

    // States in which the per-play timeout counter advances.
    assign conta_s = (estado_r == SOLTA) || (estado_r == AGUARDA) || (estado_r == FILTRA);

    // Debounce completes on this edge: candidate held for the final sample.
    assign deb_fim_s = (estado_r == FILTRA) && (bus.chaves == candidato_r)
                       && (deb_cnt_r == DEB_W'(DEBOUNCE_CYCLES - 1));

    // Expiry on this edge; a completing debounce or a clear request wins.
    assign expira_s = conta_s && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))
                      && !bus.zera_timeout && !deb_fim_s;

    // Play-detection FSM with debounce/timeout counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r       <= OCIOSO;
            candidato_r    <= 4'd0;
            jogada_r       <= 4'd0;
            deb_cnt_r      <= {DEB_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            timeout_r      <= 1'b0;
            jogada_feita_r <= 1'b0;
        end else if (!bus.habilita) begin
            // Disabling overrides every other event.
            estado_r       <= OCIOSO;
            deb_cnt_r      <= {DEB_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            timeout_r      <= 1'b0;
            jogada_feita_r <= 1'b0;
        end else if (deb_fim_s) begin
            // Accept the play; the pulse is high for the whole EMITE cycle.
            estado_r       <= EMITE;
            jogada_r       <= candidato_r;
            deb_cnt_r      <= {DEB_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            jogada_feita_r <= 1'b1;
        end else if (expira_s) begin
            // Counter moves to TIMEOUT_CYCLES and saturates there.
            estado_r       <= ESGOTADO;
            timeout_r      <= 1'b1;
            cnt_r          <= cnt_r + CNT_W'(1'b1);
            jogada_feita_r <= 1'b0;
        end else begin
            jogada_feita_r <= 1'b0;
            if (conta_s) begin
                if (bus.zera_timeout) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                end
            end else begin
                cnt_r <= cnt_r;
            end

            case (estado_r)
                OCIOSO: begin
                    estado_r  <= SOLTA;
                    cnt_r     <= {CNT_W{1'b0}};
                    timeout_r <= 1'b0;
                end
                SOLTA: begin
                    // A key held from before must be released first.
                    if (bus.chaves == 4'd0) begin
                        estado_r <= AGUARDA;
                    end else begin
                        estado_r <= SOLTA;
                    end
                end
                AGUARDA: begin
                    if ((bus.chaves != 4'd0) && !chave_invalida_s) begin
                        estado_r    <= FILTRA;
                        candidato_r <= bus.chaves;
                        deb_cnt_r   <= DEB_W'(1'b1);
                    end else begin
                        estado_r <= AGUARDA;
                    end
                end
                FILTRA: begin
                    if ((bus.chaves == 4'd0) || chave_invalida_s) begin
                        estado_r  <= AGUARDA;
                        deb_cnt_r <= {DEB_W{1'b0}};
                    end else if (bus.chaves == candidato_r) begin
                        deb_cnt_r <= deb_cnt_r + DEB_W'(1'b1);
                    end else begin
                        // A different key restarts the debounce window.
                        candidato_r <= bus.chaves;
                        deb_cnt_r   <= DEB_W'(1'b1);
                    end
                end
                EMITE: begin
                    estado_r <= SOLTA;
                    if (bus.zera_timeout) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ESGOTADO: begin
                    // Keys are ignored until the control unit clears the flag.
                    if (bus.zera_timeout) begin
                        estado_r  <= SOLTA;
                        timeout_r <= 1'b0;
                        cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        estado_r <= ESGOTADO;
                    end
                end
                default: begin
                    estado_r  <= OCIOSO;
                    deb_cnt_r <= {DEB_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.jogada              = jogada_r;
    assign bus.jogada_feita        = jogada_feita_r;
    assign bus.timeout             = timeout_r;
    assign bus.db_estado           = estado_r;
    assign bus.db_contagem_timeout = cnt_r;
    assign bus.db_chave_invalida   = chave_invalida_s
                                     && ((estado_r == AGUARDA) || (estado_r == FILTRA));

endmodule
